regbank_ctx_ctrl: RTL and testbench

//  Context-switch sequencer for the dual-bank register file (2 banks x 32 regs).

---
 rtl/regbank_ctx_ctrl.sv | 110 +++++++++++
 tb/tb_regbank_ctx_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regbank_ctx_ctrl.sv
// Context-switch sequencer for the dual-bank register file: spill active bank, flip, refill.
// Latency: 2..67 busy cycles per request; no backpressure, ctx_req is ignored unless idle.
module regbank_ctx_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctx_req,
  input  logic                  ctx_save,
  input  logic                  ctx_restore,
  input  logic [ADDR_WIDTH-1:0] save_base,
  input  logic [ADDR_WIDTH-1:0] restore_base,
  output logic                  busy,
  output logic                  ctx_done,
  output logic                  cur_bank,
  output logic [4:0]            rf_rd_reg,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic [4:0]            rf_wr_reg,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, SAVE, SWAP, RESTORE, DONE} state_t;

  state_t                state;
  logic [5:0]            idx;
  logic                  restoreFlag;
  logic [ADDR_WIDTH-1:0] saveBase;
  logic [ADDR_WIDTH-1:0] restoreBase;
  logic                  curBank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      restoreFlag <= 1'b0;
      saveBase    <= '0;
      restoreBase <= '0;
      curBank     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idx <= '0;
          if (ctx_req) begin
            restoreFlag <= ctx_restore;
            saveBase    <= save_base;
            restoreBase <= restore_base;
            state       <= ctx_save ? SAVE : SWAP;
          end
        end
        SAVE: begin
          if (idx == 6'd31) begin
            idx   <= '0;
            state <= SWAP;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        SWAP: begin
          curBank <= ~curBank;
          idx     <= '0;
          state   <= restoreFlag ? RESTORE : DONE;
        end
        RESTORE: begin
          // One extra cycle drains the last memory read into r31.
          if (idx == 6'd32) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic inSave;
  logic restRd;
  logic restWr;

  assign inSave = (state == SAVE);
  assign restRd = (state == RESTORE) && !idx[5];
  assign restWr = (state == RESTORE) && (idx != 6'd0);

  assign busy     = (state != IDLE);
  assign ctx_done = (state == DONE);
  assign cur_bank = curBank;

  assign rf_rd_reg = inSave ? idx[4:0] : 5'd0;
  assign mem_we    = inSave;
  assign mem_wdata = inSave ? rf_rd_data : '0;
  assign mem_re    = restRd;
  assign mem_addr  = inSave ? saveBase + ADDR_WIDTH'(idx)
                   : restRd ? restoreBase + ADDR_WIDTH'(idx)
                   : '0;

  // Write side trails the read side by one cycle; r0 is hardwired and never written.
  assign rf_wr_reg  = restWr ? (idx[4:0] - 5'd1) : 5'd0;
  assign rf_wr_data = restWr ? mem_rdata : '0;
  assign rf_wr_en   = restWr && (idx != 6'd1);

endmodule

// File: tb/tb_regbank_ctx_ctrl.sv
// Bench for regbank_ctx_ctrl: register-file and memory models with a write scoreboard.
module tb_regbank_ctx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctx_req, ctx_save, ctx_restore;
  logic [31:0] save_base, restore_base;
  logic        busy, ctx_done, cur_bank;
  logic [4:0]  rf_rd_reg, rf_wr_reg;
  logic [31:0] rf_rd_data, rf_wr_data;
  logic        rf_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  always #5 clk = ~clk;

  regbank_ctx_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctx_req(ctx_req), .ctx_save(ctx_save), .ctx_restore(ctx_restore),
    .save_base(save_base), .restore_base(restore_base),
    .busy(busy), .ctx_done(ctx_done), .cur_bank(cur_bank),
    .rf_rd_reg(rf_rd_reg), .rf_rd_data(rf_rd_data),
    .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] rf [2][32];
  logic [31:0] mem [logic [31:0]];

  int nChecks = 0;
  int nErrors = 0;
  int busyCyc = 0;
  int doneCnt = 0;
  int lastDoneCyc = 0;
  bit restWin = 1'b0;
  logic expBank = 1'b0;
  logic [63:0] expMemQ [$];
  logic [63:0] expRfQ [$];

  function automatic logic [31:0] memRd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rfRd(input logic b, input int r);
    return (r == 0) ? 32'h0 : rf[b][r];
  endfunction

  always_comb rf_rd_data = (rf_rd_reg == 5'd0) ? 32'h0 : rf[cur_bank][rf_rd_reg];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= memRd(mem_addr);
    if (rf_wr_en) rf[cur_bank][rf_wr_reg] <= rf_wr_data;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy) busyCyc++;
    else busyCyc = 0;
    if (ctx_done) begin
      doneCnt++;
      lastDoneCyc = busyCyc;
    end
    if (mem_we) begin
      chk("save_q_nonempty", 64'(expMemQ.size() != 0), 64'd1);
      if (expMemQ.size() != 0) chk("save_wr", {mem_addr, mem_wdata}, expMemQ.pop_front());
    end
    if (rf_wr_en) begin
      chk("rest_q_nonempty", 64'(expRfQ.size() != 0), 64'd1);
      if (expRfQ.size() != 0) chk("restore_wr", 64'({cur_bank, rf_wr_reg, rf_wr_data}), expRfQ.pop_front());
    end
    if (mem_we || mem_re) chk("we_re_excl", 64'(mem_we & mem_re), 64'd0);
    if (!busy) chk("idle_strobes", 64'({mem_we, mem_re, rf_wr_en}), 64'd0);
    if (restWin && busy) begin
      chk("rw_mem_re", 64'(mem_re), 64'(busyCyc >= 2 && busyCyc <= 33));
      chk("rw_rf_wr_en", 64'(rf_wr_en), 64'(busyCyc >= 4 && busyCyc <= 34));
      chk("rw_mem_we", 64'(mem_we), 64'd0);
    end
  end

  task automatic runSeq(input string tag, input bit sv, input bit rs,
                        input logic [31:0] sb, input logic [31:0] rb, input int expCyc);
    int n;
    int d0;
    logic newBank;
    @(negedge clk); #1;
    newBank = ~expBank;
    if (sv) for (int i = 0; i < 32; i++) expMemQ.push_back({sb + 32'(i), rfRd(expBank, i)});
    if (rs) for (int i = 1; i < 32; i++) expRfQ.push_back(64'({newBank, 5'(i), memRd(rb + 32'(i))}));
    d0 = doneCnt;
    ctx_req = 1'b1; ctx_save = sv; ctx_restore = rs; save_base = sb; restore_base = rb;
    @(negedge clk); #1;
    ctx_req = 1'b0; ctx_save = 1'b0; ctx_restore = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk); #1;
    end
    expBank = newBank;
    chk({tag, "_cycles"}, 64'(n), 64'(expCyc));
    chk({tag, "_done_cnt"}, 64'(doneCnt - d0), 64'd1);
    chk({tag, "_done_cyc"}, 64'(lastDoneCyc), 64'(expCyc));
    chk({tag, "_bank"}, 64'(cur_bank), 64'(expBank));
    chk({tag, "_memq_left"}, 64'(expMemQ.size()), 64'd0);
    chk({tag, "_rfq_left"}, 64'(expRfQ.size()), 64'd0);
  endtask

  initial begin
    logic [5:0] eb;
    logic [5:0] ed;
    int g;
    for (int b = 0; b < 2; b++) for (int r = 0; r < 32; r++) rf[b][r] = 32'h0;
    mem_rdata = 32'h0;
    rst_n = 1'b0; ctx_req = 1'b0; ctx_save = 1'b0; ctx_restore = 1'b0;
    save_base = 32'h0; restore_base = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_bank", 64'(cur_bank), 64'd0);
    chk("rst_done", 64'(ctx_done), 64'd0);
    chk("rst_strobes", 64'({mem_we, mem_re, rf_wr_en}), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_regs", 64'({rf_rd_reg, rf_wr_reg}), 64'd0);
    rst_n = 1'b1;

    // Swap-only toggles the bank each time.
    runSeq("swap1", 1'b0, 1'b0, 32'h0, 32'h0, 2);
    runSeq("swap2", 1'b0, 1'b0, 32'h0, 32'h0, 2);
    runSeq("swap3", 1'b0, 1'b0, 32'h0, 32'h0, 2);

    // Reset during SAVE at idx 10 with bank 1 active.
    @(negedge clk); #1;
    for (int i = 0; i < 32; i++) expMemQ.push_back({32'h300 + 32'(i), rfRd(expBank, i)});
    ctx_req = 1'b1; ctx_save = 1'b1; save_base = 32'h300;
    @(negedge clk); #1;
    ctx_req = 1'b0; ctx_save = 1'b0;
    g = 0;
    while (busyCyc < 11 && g < 100) begin
      g++;
      @(negedge clk); #1;
    end
    chk("midsave_q_left", 64'(expMemQ.size()), 64'd21);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_bank", 64'(cur_bank), 64'd0);
    chk("midrst_strobes", 64'({mem_we, mem_re, rf_wr_en}), 64'd0);
    @(posedge clk); #1;
    chk("midrst_edge_strobes", 64'({mem_we, mem_re, rf_wr_en, busy}), 64'd0);
    expMemQ.delete();
    expBank = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Full save + restore.
    for (int i = 0; i < 32; i++) begin
      rf[0][i] = 32'h100 + 32'(i);
      rf[1][i] = 32'h0;
      mem[32'h80 + 32'(i)] = 32'hA00 + 32'(i);
    end
    runSeq("full", 1'b1, 1'b1, 32'h40, 32'h80, 67);
    for (int i = 0; i < 32; i++) begin
      chk("full_mem", 64'(memRd(32'h40 + 32'(i))), 64'((i == 0) ? 0 : 32'h100 + i));
      chk("full_bank1", 64'(rf[1][i]), 64'((i == 0) ? 0 : 32'hA00 + i));
    end

    // Save-only with wrapping base address.
    runSeq("wrap", 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 34);
    chk("wrap_top", 64'(memRd(32'hFFFF_FFFF)), 64'hA0F);
    chk("wrap_zero", 64'(memRd(32'h0)), 64'hA10);
    chk("wrap_end", 64'(memRd(32'hF)), 64'hA1F);

    // ctx_req held high through DONE: one sequence, one idle cycle, then a new accept.
    eb = 6'b011011;
    ed = 6'b010010;
    @(negedge clk); #1;
    ctx_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      chk("hold_busy", 64'(busy), 64'(eb[k]));
      chk("hold_done", 64'(ctx_done), 64'(ed[k]));
      if (k == 3) ctx_req = 1'b0;
    end
    chk("hold_bank", 64'(cur_bank), 64'(expBank));

    // Restore only into bank 1.
    for (int i = 0; i < 32; i++) mem[32'h200 + 32'(i)] = 32'hC00 + 32'(i);
    rf[1][0] = 32'h0;
    restWin = 1'b1;
    runSeq("rest", 1'b0, 1'b1, 32'h0, 32'h200, 35);
    restWin = 1'b0;
    chk("rest_r5", 64'(rf[1][5]), 64'hC05);
    chk("rest_r31", 64'(rf[1][31]), 64'hC1F);
    chk("rest_r0", 64'(rf[1][0]), 64'h0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
